// File: rtl/vga_vtim_gen.sv
// vga_vtim_gen: one-dimensional video timing generator (use one instance per
// axis). A period counter C runs 0..Tlen over enabled cycles and is split into
// SYNC, gate-delay, GATE and TAIL phases. The timing inputs and sync polarity
// are captured into shadow registers at the start of each period, so the
// inputs may be rewritten at any time without disturbing the current period.
//
// Qualifier semantics: there is no valid/ready handshake on this block. ena is
// a pure clock qualifier. An edge with ena=1 advances the counter and reloads
// every output. An edge with ena=0 leaves every register untouched. Done is
// therefore a level that is only meaningful as a pulse when sampled together
// with ena=1. rst overrides ena.
module vga_vtim_gen #(
  parameter int   SW   = 8,
  parameter int   CW   = 16,
  parameter logic SPOL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [SW-1:0] Tsync,
  input  logic [SW-1:0] Tgdel,
  input  logic [CW-1:0] Tgate,
  input  logic [CW-1:0] Tlen,
  input  logic          pol,
  output logic          Sync,
  output logic          Gate,
  output logic          Done,
  output logic [CW-1:0] Pos,
  output logic [2:0]    Phase
);

  // Phase boundary arithmetic: Ts + Td + Tg + 2 needs at least CW+1 bits.
  // Two extra bits keep the sum safe even when SW is as wide as CW.
  localparam int XW = CW + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_GDEL = 3'd2,
    ST_GATE = 3'd3,
    ST_TAIL = 3'd4
  } phase_t;

  // State and period counter
  phase_t        r_phase;
  logic [CW-1:0] r_c;

  // Shadow copies of the timing inputs for the period in progress
  logic [SW-1:0] r_ts;
  logic [SW-1:0] r_td;
  logic [CW-1:0] r_tg;
  logic [CW-1:0] r_tl;
  logic          r_pol;

  // Registered outputs
  logic          r_sync;
  logic          r_gate;
  logic          r_done;
  logic [CW-1:0] r_pos;

  // Next-edge values
  logic          w_wrap;
  logic [SW-1:0] w_ts_n;
  logic [SW-1:0] w_td_n;
  logic [CW-1:0] w_tg_n;
  logic [CW-1:0] w_tl_n;
  logic          w_pol_n;
  logic [CW-1:0] w_c_n;
  logic [XW-1:0] w_cx;
  logic [XW-1:0] w_sync_end;
  logic [XW-1:0] w_gdel_end;
  logic [XW-1:0] w_gate_start;
  logic [XW-1:0] w_gate_end;
  logic [XW-1:0] w_gate_off;
  phase_t        w_phase_n;
  logic          w_sync_n;
  logic          w_gate_n;
  logic          w_done_n;
  logic [CW-1:0] w_pos_n;

  // A new period starts on the first enabled edge out of IDLE, or on the edge
  // following the last count of the current period (C == Tl). The truncation
  // case needs no special handling: whatever phase is current, reaching Tl
  // restarts the period.
  assign w_wrap = (r_phase == ST_IDLE) || (r_c == r_tl);

  // Entering C=0 takes fresh input values; otherwise the shadows stay put.
  assign w_ts_n  = w_wrap ? Tsync : r_ts;
  assign w_td_n  = w_wrap ? Tgdel : r_td;
  assign w_tg_n  = w_wrap ? Tgate : r_tg;
  assign w_tl_n  = w_wrap ? Tlen  : r_tl;
  assign w_pol_n = w_wrap ? pol   : r_pol;

  // r_c never exceeds r_tl, so the increment cannot overflow CW bits.
  assign w_c_n = w_wrap ? '0 : (r_c + CW'(1));
  assign w_cx  = XW'(w_c_n);

  // Last count of each phase, expressed on the widened counter.
  assign w_sync_end   = XW'(w_ts_n);
  assign w_gdel_end   = XW'(w_ts_n) + XW'(w_td_n) + XW'(1);
  assign w_gate_start = XW'(w_ts_n) + XW'(w_td_n) + XW'(2);
  assign w_gate_end   = XW'(w_ts_n) + XW'(w_td_n) + XW'(w_tg_n) + XW'(2);

  // Map the next count onto its phase.
  always_comb begin
    w_phase_n = ST_TAIL;
    if (w_cx <= w_sync_end) begin
      w_phase_n = ST_SYNC;
    end else if (w_cx <= w_gdel_end) begin
      w_phase_n = ST_GDEL;
    end else if (w_cx <= w_gate_end) begin
      w_phase_n = ST_GATE;
    end
  end

  // Position within the gate. The offset is at most Tg, so it fits CW bits.
  assign w_gate_off = w_cx - w_gate_start;
  assign w_pos_n    = (w_phase_n == ST_GATE) ? w_gate_off[CW-1:0] : '0;

  // Output values for the count being entered.
  assign w_sync_n = (w_phase_n == ST_SYNC) ^ w_pol_n;
  assign w_gate_n = (w_phase_n == ST_GATE);
  assign w_done_n = (w_c_n == w_tl_n);

  // Phase FSM, period counter, shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= ST_IDLE;
      r_c     <= '0;
      r_ts    <= '0;
      r_td    <= '0;
      r_tg    <= '0;
      r_tl    <= '0;
      r_pol   <= SPOL;
      r_sync  <= SPOL;
      r_gate  <= 1'b0;
      r_done  <= 1'b0;
      r_pos   <= '0;
    end else if (ena) begin
      r_phase <= w_phase_n;
      r_c     <= w_c_n;
      r_ts    <= w_ts_n;
      r_td    <= w_td_n;
      r_tg    <= w_tg_n;
      r_tl    <= w_tl_n;
      r_pol   <= w_pol_n;
      r_sync  <= w_sync_n;
      r_gate  <= w_gate_n;
      r_done  <= w_done_n;
      r_pos   <= w_pos_n;
    end
  end

  assign Sync  = r_sync;
  assign Gate  = r_gate;
  assign Done  = r_done;
  assign Pos   = r_pos;
  assign Phase = r_phase;

endmodule

// File: tb/tb_vga_vtim_gen.sv
// Bench for vga_vtim_gen. The reference model builds the whole expected output
// sequence of a period at the moment the period starts: Tsync+1 sync entries,
// Tgdel+1 delay entries, Tgate+1 gate entries and then tail entries, cut or
// padded to Tlen+1 entries, with Done set on the last entry. One entry is
// consumed per enabled clock.
module tb_vga_vtim_gen;

  localparam int   SW   = 8;
  localparam int   CW   = 16;
  localparam logic SPOL = 1'b0;

  typedef struct packed {
    logic [2:0]    ph;
    logic          sy;
    logic          ga;
    logic          dn;
    logic [CW-1:0] pos;
  } out_t;

  // Clock / reset / DUT
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [SW-1:0] Tsync = '0;
  logic [SW-1:0] Tgdel = '0;
  logic [CW-1:0] Tgate = '0;
  logic [CW-1:0] Tlen  = '0;
  logic          pol   = 1'b0;
  logic          Sync;
  logic          Gate;
  logic          Done;
  logic [CW-1:0] Pos;
  logic [2:0]    Phase;

  always #5 clk = ~clk;

  vga_vtim_gen #(.SW(SW), .CW(CW), .SPOL(SPOL)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .Tsync (Tsync),
    .Tgdel (Tgdel),
    .Tgate (Tgate),
    .Tlen  (Tlen),
    .pol   (pol),
    .Sync  (Sync),
    .Gate  (Gate),
    .Done  (Done),
    .Pos   (Pos),
    .Phase (Phase)
  );

  // Scoreboard state
  out_t exp_q[$];
  out_t exp_v;
  int   m_len = 0;
  int   m_c   = 0;
  int   checks   = 0;
  int   failures = 0;
  int   clk_idx  = 0;

  function automatic out_t got_v();
    out_t g;
    g.ph  = Phase;
    g.sy  = Sync;
    g.ga  = Gate;
    g.dn  = Done;
    g.pos = Pos;
    return g;
  endfunction

  function automatic out_t reset_v();
    out_t e;
    e    = '0;
    e.sy = SPOL;
    return e;
  endfunction

  // Expected output sequence of one period, from the inputs present now.
  function automatic void build_period();
    out_t e;
    int   n;
    n = int'(Tlen) + 1;
    exp_q.delete();
    for (int k = 0; k <= int'(Tsync) && exp_q.size() < n; k++) begin
      e = '0; e.ph = 3'd1; e.sy = ~pol; exp_q.push_back(e);
    end
    for (int k = 0; k <= int'(Tgdel) && exp_q.size() < n; k++) begin
      e = '0; e.ph = 3'd2; e.sy = pol; exp_q.push_back(e);
    end
    for (int k = 0; k <= int'(Tgate) && exp_q.size() < n; k++) begin
      e = '0; e.ph = 3'd3; e.sy = pol; e.ga = 1'b1; e.pos = CW'(k); exp_q.push_back(e);
    end
    while (exp_q.size() < n) begin
      e = '0; e.ph = 3'd4; e.sy = pol; exp_q.push_back(e);
    end
    e = exp_q[n-1];
    e.dn = 1'b1;
    exp_q[n-1] = e;
    m_len = n;
  endfunction

  // Driver: one clock with the given ena/rst, advancing the model.
  task automatic tick(input bit en, input bit r);
    @(negedge clk);
    ena = en;
    rst = r;
    @(posedge clk);
    clk_idx++;
    if (r) begin
      exp_q.delete();
      exp_v = reset_v();
      m_c   = 0;
    end else if (en) begin
      if (exp_q.size() == 0) build_period();
      exp_v = exp_q.pop_front();
      m_c   = m_len - 1 - exp_q.size();
    end
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic set_timing(input int ts, input int td, input int tg, input int tl, input bit p);
    Tsync = SW'(ts);
    Tgdel = SW'(td);
    Tgate = CW'(tg);
    Tlen  = CW'(tl);
    pol   = p;
  endtask

  // Advance with ena=1 until the model reaches count c (bounded).
  task automatic run_to_c(input int c);
    int n;
    n = 0;
    do begin
      tick(1'b1, 1'b0);
      n++;
    end while (m_c != c && n < 64);
    checks++;
    if (m_c != c) begin
      failures++;
      $display("FAIL run_to_c: count=%0d required=%0d", m_c, c);
    end
  endtask

  task automatic test_reset();
    set_timing(2, 1, 4, 15, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    checks++;
    if (Phase !== 3'd0) begin failures++; $display("FAIL reset_phase: got=%0d required=0", Phase); end
    checks++;
    if (Sync !== SPOL) begin failures++; $display("FAIL reset_sync: got=%b required=%b", Sync, SPOL); end
    checks++;
    if (Gate !== 1'b0) begin failures++; $display("FAIL reset_gate: got=%b required=0", Gate); end
    checks++;
    if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got=%b required=0", Done); end
    checks++;
    if (Pos !== '0) begin failures++; $display("FAIL reset_pos: got=%0d required=0", Pos); end
    // Holding with ena low after reset keeps IDLE.
    tick(1'b0, 1'b0);
    checks++;
    if (got_v() !== reset_v()) begin failures++; $display("FAIL reset_hold: got=%h required=%h", got_v(), reset_v()); end
  endtask

  task automatic test_basic();
    set_timing(2, 1, 4, 15, 1'b0);
    do_reset();
    for (int i = 0; i < 34; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (got_v() !== exp_v) begin failures++; $display("FAIL basic_model: clk=%0d got=%h required=%h", i, got_v(), exp_v); end
      checks++;
      if (Sync !== (i % 16 <= 2)) begin failures++; $display("FAIL basic_sync: clk=%0d got=%b", i, Sync); end
      checks++;
      if (Gate !== (i % 16 >= 5 && i % 16 <= 9) || (Gate && Pos !== CW'(i % 16 - 5))) begin
        failures++; $display("FAIL basic_gate: clk=%0d gate=%b pos=%0d", i, Gate, Pos);
      end
      checks++;
      if (Done !== (i % 16 == 15)) begin failures++; $display("FAIL basic_done: clk=%0d got=%b", i, Done); end
    end
  endtask

  task automatic test_truncate();
    set_timing(2, 1, 4, 6, 1'b0);
    do_reset();
    for (int i = 0; i < 21; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (got_v() !== exp_v) begin failures++; $display("FAIL trunc_model: clk=%0d got=%h required=%h", i, got_v(), exp_v); end
      checks++;
      if (Gate !== (i % 7 >= 5) || Done !== (i % 7 == 6) || Sync !== (i % 7 <= 2)) begin
        failures++; $display("FAIL trunc_shape: clk=%0d gate=%b done=%b sync=%b", i, Gate, Done, Sync);
      end
    end
  endtask

  task automatic test_ena_toggle();
    int first_done;
    int ndone;
    first_done = -1;
    ndone = 0;
    set_timing(2, 1, 4, 15, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      tick((i % 2) == 0, 1'b0);
      checks++;
      if (got_v() !== exp_v) begin failures++; $display("FAIL ena_model: clk=%0d got=%h required=%h", i, got_v(), exp_v); end
      if (ena && Done) begin
        if (first_done < 0) first_done = i;
        else begin
          checks++;
          if (i - first_done != 32) begin failures++; $display("FAIL ena_period: got=%0d required=32", i - first_done); end
        end
        ndone++;
      end
    end
    checks++;
    if (ndone != 2) begin failures++; $display("FAIL ena_done_count: got=%0d required=2", ndone); end
  endtask

  task automatic test_pol_change();
    bit second;
    second = 1'b0;
    set_timing(2, 1, 4, 15, 1'b0);
    do_reset();
    run_to_c(8);
    pol = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 1'b0);
      if (m_c == 0) second = 1'b1;
      checks++;
      if (got_v() !== exp_v) begin failures++; $display("FAIL pol_model: clk=%0d got=%h required=%h", i, got_v(), exp_v); end
      checks++;
      if (Sync !== ((m_c <= 2) ^ second)) begin failures++; $display("FAIL pol_sync: c=%0d got=%b", m_c, Sync); end
    end
    pol = 1'b0;
  endtask

  task automatic test_tgate_change();
    bit second;
    second = 1'b0;
    set_timing(2, 1, 4, 15, 1'b0);
    do_reset();
    run_to_c(6);
    Tgate = CW'(2);
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 1'b0);
      if (m_c == 0) second = 1'b1;
      checks++;
      if (got_v() !== exp_v) begin failures++; $display("FAIL tg_model: clk=%0d got=%h required=%h", i, got_v(), exp_v); end
      checks++;
      if (Gate !== (m_c >= 5 && m_c <= (second ? 7 : 9))) begin failures++; $display("FAIL tg_gate: c=%0d got=%b", m_c, Gate); end
    end
  endtask

  task automatic test_reset_mid();
    set_timing(2, 1, 4, 15, 1'b0);
    do_reset();
    run_to_c(7);
    checks++;
    if (Gate !== 1'b1 || Pos !== CW'(2)) begin failures++; $display("FAIL rmid_pre: gate=%b pos=%0d required gate=1 pos=2", Gate, Pos); end
    tick(1'b1, 1'b1);
    checks++;
    if (Gate !== 1'b0 || Pos !== '0 || Phase !== 3'd0) begin
      failures++; $display("FAIL rmid_reset: gate=%b pos=%0d phase=%0d required 0/0/0", Gate, Pos, Phase);
    end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (Phase !== 3'd1 || Sync !== 1'b1 || Done !== 1'b0) begin
      failures++; $display("FAIL rmid_restart: phase=%0d sync=%b done=%b required 1/1/0", Phase, Sync, Done);
    end
    checks++;
    if (got_v() !== exp_v) begin failures++; $display("FAIL rmid_model: got=%h required=%h", got_v(), exp_v); end
  endtask

  task automatic test_tl_zero();
    set_timing(3, 2, 5, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (Phase !== 3'd1 || Sync !== 1'b1 || Done !== 1'b1 || Gate !== 1'b0) begin
        failures++; $display("FAIL tl0: clk=%0d phase=%0d sync=%b done=%b gate=%b", i, Phase, Sync, Done, Gate);
      end
    end
  endtask

  task automatic test_random();
    set_timing(1, 0, 3, 10, 1'b0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_timing($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 10),
                   $urandom_range(0, 30), 1'($urandom_range(0, 1)));
      end
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      checks++;
      if (got_v() !== exp_v) begin failures++; $display("FAIL rand_model: clk=%0d got=%h required=%h", i, got_v(), exp_v); end
    end
  endtask

  initial begin
    exp_v = reset_v();
    test_reset();
    test_basic();
    test_truncate();
    test_ena_toggle();
    test_pol_change();
    test_tgate_change();
    test_reset_mid();
    test_tl_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_vtim_gen.md
VGA_VTIM_GEN -- requirements
Module: vga_vtim_gen

Interface
REQ-001 Parameter SW, default 8: width of Tsync and Tgdel.
REQ-002 Parameter CW, default 16: width of Tgate, Tlen and Pos.
REQ-003 Parameter SPOL, default 0: reset value of the sync-polarity register (0 = active-high Sync).
REQ-004 clk  in  1  master clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ena  in  1  count enable; when low, all state and outputs hold.
REQ-007 Tsync  in  SW  sync length; phase lasts Tsync+1 enabled cycles.
REQ-008 Tgdel  in  SW  gate delay; phase lasts Tgdel+1 enabled cycles.
REQ-009 Tgate  in  CW  gate length; phase lasts Tgate+1 enabled cycles.
REQ-010 Tlen  in  CW  total period; period lasts Tlen+1 enabled cycles.
REQ-011 pol  in  1  sync polarity; 1 inverts Sync.
REQ-012 Sync  out  1  sync pulse, polarity per latched pol.
REQ-013 Gate  out  1  active-video gate.
REQ-014 Done  out  1  one-cycle pulse on the last enabled cycle of a period.
REQ-015 Pos  out  CW  index within gate, 0..Tgate; 0 outside gate.
REQ-016 Phase  out  3  current state encoding: IDLE=0, SYNC=1, GDEL=2, GATE=3, TAIL=4.

Function
REQ-017 The block SHALL run a period counter C, 0..Tlen, over enabled cycles; all outputs SHALL be registered and SHALL reflect C after each enabled edge.
REQ-018 The state machine SHALL be IDLE -> SYNC -> GDEL -> GATE -> TAIL -> SYNC, advancing only on enabled cycles.
REQ-019 IDLE SHALL be entered only from reset; the first enabled edge after reset SHALL enter SYNC with C=0.
REQ-020 SYNC SHALL span C = 0..Ts.
REQ-021 GDEL SHALL span C = Ts+1..Ts+Td+1.
REQ-022 GATE SHALL span C = Ts+Td+2..Ts+Td+Tg+2.
REQ-023 TAIL SHALL span the remaining C up to Tl.
REQ-024 Ts, Td, Tg, Tl and pol SHALL be latched into shadow registers when C=0 is entered; input changes mid-period SHALL take effect only from the next period.
REQ-025 Sync SHALL be (Phase==SYNC) XOR shadow pol.
REQ-026 Gate SHALL be (Phase==GATE).
REQ-027 Pos SHALL increment by 1 per enabled cycle in GATE, starting at 0.
REQ-028 Done SHALL be high exactly when C==Tl; on the next enabled edge, C SHALL wrap to 0 and the state SHALL go to SYNC.
REQ-029 Truncation: if C reaches Tl before TAIL, Done SHALL still pulse at C==Tl and the period SHALL restart in SYNC, from whatever phase is current (a gate is cut short; Pos stops at its last value, then returns to 0).
REQ-030 If Tl=0, every enabled cycle SHALL be C=0 with Sync active and Done high.
REQ-031 Internal phase and period counters SHALL be sized so that sum of the Ts/Td/Tg terms plus 2 cannot wrap: CW+1 bits minimum.
REQ-032 While ena is low, Done SHALL stay at its held value; it SHALL only be interpreted as a pulse when qualified by ena.

Reset
REQ-033 rst SHALL take priority over ena.
REQ-034 On rst, the block SHALL set Phase=IDLE, C=0, Gate=0, Done=0 and Pos=0.
REQ-035 On rst, Sync SHALL be set to its inactive level per SPOL, and the shadow pol SHALL be loaded with SPOL.
REQ-036 On rst, the shadow timing registers SHALL be set to 0.
REQ-037 Reset asserted mid-period SHALL abort the period; the first enabled edge after release SHALL restart at C=0 in SYNC.

Verification
REQ-038 Ts=2, Td=1, Tg=4, Tl=15, pol=0, ena=1 -> Sync high C0-2; Gate high C5-9 with Pos 0,1,2,3,4; Done at C15; period repeats every 16 clocks.
REQ-039 Same timing with Tl=6 -> Gate high C5-6 only (Pos 0,1); Done at C6; Sync re-asserts on the next clock.
REQ-040 Same timing with ena toggling 1,0,1,0 -> every transition occurs on enabled clocks only; the period spans 32 clocks; outputs are held during ena=0.
REQ-041 pol changed 0->1 at C=8 -> current period unaffected; next period Sync low C0-2, high elsewhere.
REQ-042 Tgate changed from 4 to 2 at C=6 -> current gate still ends at C9; next period gate spans C5-7.
REQ-043 rst pulsed at C=7 during gate -> Gate=0, Pos=0, Phase=IDLE next clock; first enabled edge after release gives Sync active, C=0.
